fetch_next_pc_unit: RTL

- Fetch-stage PC generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters.
- Holds the architectural fetch PC and each cycle selects the next PC from three sources: sequential, predicted, or redirected.
- Drives the predictedNextPC / isBranchTakenPredicted tags that travel down the pipeline to the hazard/branch controller.
- Consumes that controller's isDataHazard (stall) and isBranchPredictMiss (redirect).

---
 rtl/fetch_next_pc_unit_pkg.sv | 30 +++
 rtl/fetch_next_pc_unit_btb.sv | 81 ++++++++
 rtl/fetch_next_pc_unit.sv | 69 ++++++
 3 files changed

// File: rtl/fetch_next_pc_unit_pkg.sv
// Shared fetch-stage types: PC, BTB entry view, 2-bit direction counter.
// Used by fetch_next_pc_unit and branch_target_buffer.
package fetch_next_pc_unit_pkg;

   typedef logic [31:0] pc_t;

   localparam pc_t RESET_VECTOR_DEFAULT = 32'h0000_0000;

   typedef logic [1:0] counter_t;

   localparam counter_t STRONG_NT = 2'b00;
   localparam counter_t WEAK_NT   = 2'b01;
   localparam counter_t WEAK_T    = 2'b10;
   localparam counter_t STRONG_T  = 2'b11;

   // Tag is held zero-extended to the widest possible tag (1 BTB entry per word index bit).
   typedef struct packed {
      logic        valid;
      logic [29:0] tag;
      pc_t         target;
   } btb_entry_t;

   function automatic counter_t counter_next(input counter_t cnt, input logic taken);
      if (taken) begin
         return (cnt == STRONG_T) ? STRONG_T : cnt + 2'b01;
      end
      return (cnt == STRONG_NT) ? STRONG_NT : cnt - 2'b01;
   endfunction

endpackage

// File: rtl/fetch_next_pc_unit_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational on the fetch PC; updates land on the next rising edge.
module branch_target_buffer
   import fetch_next_pc_unit_pkg::*;
#(
   parameter int ENTRY_NUM = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_lookup_pc,
   output logic        o_hit,
   output logic [31:0] o_target,
   input  logic        i_update_en,
   input  logic [31:0] i_update_pc,
   input  logic        i_update_taken,
   input  logic [31:0] i_update_target
);

   localparam int INDEX_WIDTH = $clog2(ENTRY_NUM);
   localparam int TAG_WIDTH   = 30 - INDEX_WIDTH;

   typedef logic [INDEX_WIDTH-1:0] index_t;
   typedef logic [TAG_WIDTH-1:0]   tag_t;

   logic [ENTRY_NUM-1:0] r_valid;
   counter_t             r_counter [ENTRY_NUM];
   tag_t                 r_tag     [ENTRY_NUM];
   logic [29:0]          r_target  [ENTRY_NUM];

   index_t     w_rd_idx;
   tag_t       w_rd_tag;
   index_t     w_wr_idx;
   tag_t       w_wr_tag;
   btb_entry_t w_rd_entry;
   counter_t   w_rd_counter;
   logic       w_wr_hit;
   logic       w_unused_bits;

   assign w_rd_idx = i_lookup_pc[INDEX_WIDTH+1:2];
   assign w_rd_tag = i_lookup_pc[31:INDEX_WIDTH+2];
   assign w_wr_idx = i_update_pc[INDEX_WIDTH+1:2];
   assign w_wr_tag = i_update_pc[31:INDEX_WIDTH+2];

   assign w_rd_entry = '{valid:  r_valid[w_rd_idx],
                         tag:    30'(r_tag[w_rd_idx]),
                         target: {r_target[w_rd_idx], 2'b00}};
   assign w_rd_counter = r_counter[w_rd_idx];

   // Taken prediction needs a valid matching entry whose counter sits in the upper half.
   assign o_hit    = w_rd_entry.valid && (w_rd_entry.tag == 30'(w_rd_tag)) && w_rd_counter[1];
   assign o_target = w_rd_entry.target;

   assign w_wr_hit = r_valid[w_wr_idx] && (r_tag[w_wr_idx] == w_wr_tag);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
         for (int i = 0; i < ENTRY_NUM; i++) begin
            r_counter[i] <= WEAK_NT;
         end
      end else if (i_update_en) begin
         if (w_wr_hit) begin
            r_counter[w_wr_idx] <= counter_next(r_counter[w_wr_idx], i_update_taken);
         end else if (i_update_taken) begin
            r_valid[w_wr_idx]   <= 1'b1;
            r_counter[w_wr_idx] <= WEAK_T;
         end
      end
   end

   // NOTE: tag/target arrays are plain storage with no reset; r_valid alone decides whether they are meaningful.
   always_ff @(posedge clk) begin
      if (i_update_en && i_update_taken) begin
         r_tag[w_wr_idx]    <= w_wr_tag;
         r_target[w_wr_idx] <= i_update_target[31:2];
      end
   end

   assign w_unused_bits = ^{i_lookup_pc[1:0], i_update_pc[1:0], i_update_target[1:0]};

endmodule

// File: rtl/fetch_next_pc_unit.sv
// Fetch PC register and next-PC select (redirect > stall > prediction).
// Branch prediction via branch_target_buffer is built only when BTB_PREDICT_EN is defined.
module fetch_next_pc_unit
   import fetch_next_pc_unit_pkg::*;
#(
   parameter int  ENTRY_NUM    = 64,
   parameter pc_t RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        isBranchPredictMiss,
   input  logic [31:0] redirectPc,
   input  logic        updateEnable,
   input  logic [31:0] updatePc,
   input  logic        updateTaken,
   input  logic [31:0] updateTarget,
   output logic [31:0] pc,
   output logic [31:0] predictedNextPC,
   output logic        isBranchTakenPredicted
);

   pc_t  r_pc;
   pc_t  w_seq_pc;
   pc_t  w_btb_target;
   logic w_btb_hit;
   logic w_unused_bits;

   assign w_seq_pc = r_pc + 32'd4;

`ifdef BTB_PREDICT_EN
   branch_target_buffer #(
      .ENTRY_NUM(ENTRY_NUM)
   ) u_btb (
      .clk             (clk),
      .rst             (rst),
      .i_lookup_pc     (r_pc),
      .o_hit           (w_btb_hit),
      .o_target        (w_btb_target),
      .i_update_en     (updateEnable),
      .i_update_pc     (updatePc),
      .i_update_taken  (updateTaken),
      .i_update_target (updateTarget)
   );

   assign w_unused_bits = ^{redirectPc[1:0]};
`else
   assign w_btb_hit     = 1'b0;
   assign w_btb_target  = '0;
   assign w_unused_bits = ^{redirectPc[1:0], updateEnable, updatePc, updateTaken,
                            updateTarget, 32'(ENTRY_NUM)};
`endif

   assign predictedNextPC        = w_btb_hit ? w_btb_target : w_seq_pc;
   assign isBranchTakenPredicted = w_btb_hit;
   assign pc                     = r_pc;

   // NOTE: state registers use non-blocking assignment so every reader sees the pre-edge value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc <= RESET_VECTOR;
      end else if (isBranchPredictMiss) begin
         r_pc <= {redirectPc[31:2], 2'b00};
      end else if (!stall) begin
         r_pc <= predictedNextPC;
      end
   end

endmodule
